// File: rtl/packed_sat_alu_seq_if.sv
// Handshake and data bundle for the packed saturating/wrapping lane ALU.
// The master drives a request (start/op/a/b); the slave answers with
// busy/done and the packed result plus per-lane overflow flags.
interface packed_sat_alu_seq_if #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4
);
  localparam int NLANES = DATA_W / LANE_W;

  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] res;
  logic [NLANES-1:0] ovf;

  // Requester side (pipeline execute stage).
  modport master (
    output start, op, a, b,
    input  busy, done, res, ovf
  );

  // ALU side.
  modport slave (
    input  start, op, a, b,
    output busy, done, res, ovf
  );
endinterface

// File: rtl/packed_sat_alu_seq.sv
// Multi-cycle packed-lane add/sub unit. Operands are split into NLANES
// independent two's-complement lanes of LANE_W bits. A single LANE_W-bit
// adder is reused, one lane per cycle, LSB lane first. Each lane either
// saturates or wraps on signed overflow and reports its own overflow flag.
//
// op encoding: op[0] selects subtract, op[1] selects wrap (else saturate).
// Timeline for a start sampled at edge T: busy for NLANES cycles, then a
// single done cycle in which res/ovf already carry the new result.
module packed_sat_alu_seq #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  packed_sat_alu_seq_if.slave bus
);

  localparam int NLANES = DATA_W / LANE_W;
  localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NLANES - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [LANE_W-1:0] SAT_MAX  = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SAT_MIN  = {1'b1, {(LANE_W-1){1'b0}}};
  localparam int MSB = LANE_W - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] acc_q;
  logic [NLANES-1:0] acc_ovf_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] res_q;
  logic [NLANES-1:0] ovf_q;

  // Next accumulator image with the current lane merged in.
  logic [DATA_W-1:0] acc_d;
  logic [NLANES-1:0] acc_ovf_d;

  // Captured operands viewed lane by lane.
  logic [LANE_W-1:0] a_lane [NLANES];
  logic [LANE_W-1:0] b_lane [NLANES];
  logic [NLANES-1:0] lane_hit;

  // Shared single-lane datapath.
  logic [LANE_W-1:0] lane_a;
  logic [LANE_W-1:0] lane_b_eff;
  logic [LANE_W-1:0] lane_s;
  logic              lane_ovf;
  logic [LANE_W-1:0] lane_res;
  logic              op_sub;
  logic              op_wrap;

  assign op_sub  = op_q[0];
  assign op_wrap = op_q[1];

  // Per-lane slicing of the captured operands and merge of the lane result
  // into the accumulator. Only the lane under the index is replaced, and only
  // while actually processing, so all other lanes hold their earlier values.
  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    assign a_lane[gi]   = a_q[gi*LANE_W +: LANE_W];
    assign b_lane[gi]   = b_q[gi*LANE_W +: LANE_W];
    assign lane_hit[gi] = (state_q == S_BUSY) && (idx_q == IDX_W'(gi));
    assign acc_d[gi*LANE_W +: LANE_W] =
        lane_hit[gi] ? lane_res : acc_q[gi*LANE_W +: LANE_W];
    assign acc_ovf_d[gi] = lane_hit[gi] ? lane_ovf : acc_ovf_q[gi];
  end

  // One lane of add/sub with overflow detect and optional saturation.
  // Subtraction is a + ~b + 1; with b inverted the add-overflow rule
  // (equal input signs, differing result sign) also covers subtraction.
  // No carry leaves the lane: the sum is truncated to LANE_W bits.
  always_comb begin
    lane_a     = a_lane[idx_q];
    lane_b_eff = op_sub ? ~b_lane[idx_q] : b_lane[idx_q];
    lane_s     = lane_a + lane_b_eff + LANE_W'(op_sub);
    lane_ovf   = (lane_a[MSB] == lane_b_eff[MSB]) && (lane_s[MSB] != lane_a[MSB]);
    lane_res   = lane_s;
    if (lane_ovf && !op_wrap) begin
      lane_res = lane_a[MSB] ? SAT_MIN : SAT_MAX;
    end
  end

  // Control FSM with registered busy/done and result outputs. A start is
  // accepted only in IDLE or DONE; while BUSY the request inputs are ignored
  // and only the captured copies feed the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      acc_ovf_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
      ovf_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end
        end

        S_BUSY: begin
          acc_q     <= acc_d;
          acc_ovf_q <= acc_ovf_d;
          if (idx_q == LAST_IDX) begin
            // Last lane: publish the full result on the edge entering DONE.
            res_q   <= acc_d;
            ovf_q   <= acc_ovf_d;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end

        S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // Back-to-back request: no idle bubble.
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end else begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_packed_sat_alu_seq.sv
// Directed bench for packed_sat_alu_seq: a 4x4-bit lane instance and an
// 2x8-bit lane instance share clock and reset. Outputs are sampled 1ns after
// the rising edge; inputs are driven at the same point.
module tb_packed_sat_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  packed_sat_alu_seq_if #(.DATA_W(16), .LANE_W(4)) bus4 ();
  packed_sat_alu_seq_if #(.DATA_W(16), .LANE_W(8)) bus8 ();

  packed_sat_alu_seq #(.DATA_W(16), .LANE_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  packed_sat_alu_seq #(.DATA_W(16), .LANE_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  always #5 clk = ~clk;

  // Present a request for one cycle, then scramble the inputs so that any
  // late re-sampling would corrupt the result.
  task automatic issue4(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    bus4.start = 1'b1; bus4.op = op; bus4.a = a; bus4.b = b;
    @(posedge clk); #1;
    bus4.start = 1'b0; bus4.op = ~op; bus4.a = ~a; bus4.b = ~b;
  endtask

  task automatic issue8(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.op = ~op; bus8.a = ~a; bus8.b = ~b;
  endtask

  // Step until done (bounded), counting busy cycles and busy/done overlap.
  task automatic wait_done4(output bit got, output int nbusy, output bit overlap);
    got = 0; nbusy = 0; overlap = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus4.busy === 1'b1 && bus4.done === 1'b1) overlap = 1;
      if (bus4.done === 1'b1) begin got = 1; break; end
      if (bus4.busy === 1'b1) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done8(output bit got, output int nbusy, output bit overlap);
    got = 0; nbusy = 0; overlap = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus8.busy === 1'b1 && bus8.done === 1'b1) overlap = 1;
      if (bus8.done === 1'b1) begin got = 1; break; end
      if (bus8.busy === 1'b1) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus4.start = 0; bus4.op = 0; bus4.a = 0; bus4.b = 0;
    bus8.start = 0; bus8.op = 0; bus8.a = 0; bus8.b = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b expected 0", bus4.busy); end
    checks++; if (bus4.done !== 1'b0) begin errors++; $display("FAIL reset_done4: got %b expected 0", bus4.done); end
    checks++; if (bus4.res !== 16'h0000) begin errors++; $display("FAIL reset_res4: got %h expected 0000", bus4.res); end
    checks++; if (bus4.ovf !== 4'h0) begin errors++; $display("FAIL reset_ovf4: got %b expected 0000", bus4.ovf); end
    checks++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin errors++; $display("FAIL reset_hs8: got busy=%b done=%b expected 0/0", bus8.busy, bus8.done); end
    checks++; if (bus8.res !== 16'h0000 || bus8.ovf !== 2'b00) begin errors++; $display("FAIL reset_res8: got %h/%b expected 0000/00", bus8.res, bus8.ovf); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: released");
  endtask

  task automatic test_add_sat();
    bit got, ov; int nb;
    issue4(2'b00, 16'h1234, 16'h4321);
    wait_done4(got, nb, ov);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL add_done: got no done expected done within bound"); end
    checks++; if (nb !== 4) begin errors++; $display("FAIL add_busy_len: got %0d expected 4", nb); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL add_overlap: got busy&done expected never"); end
    checks++; if (bus4.res !== 16'h5555) begin errors++; $display("FAIL add_res: got %h expected 5555", bus4.res); end
    checks++; if (bus4.ovf !== 4'b0000) begin errors++; $display("FAIL add_ovf: got %b expected 0000", bus4.ovf); end
    $display("add_sat: 1234+4321 -> res=%h ovf=%b busy=%0d", bus4.res, bus4.ovf, nb);
    @(posedge clk); #1;
    checks++; if (bus4.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b expected 0", bus4.done); end
    checks++; if (bus4.res !== 16'h5555) begin errors++; $display("FAIL add_res_hold: got %h expected 5555", bus4.res); end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  ovf;
  } vec_t;

  task automatic test_overflow();
    vec_t v [5];
    bit got, ov; int nb;
    v[0] = '{2'b00, 16'h7777, 16'h1111, 16'h7777, 4'b1111}; // add-sat clamps at +7
    v[1] = '{2'b10, 16'h7777, 16'h1111, 16'h8888, 4'b1111}; // add-wrap
    v[2] = '{2'b01, 16'h8888, 16'h1111, 16'h8888, 4'b1111}; // sub-sat clamps at -8
    v[3] = '{2'b01, 16'h7F80, 16'hF101, 16'h7E8F, 4'b1000}; // mixed lanes
    v[4] = '{2'b11, 16'h8888, 16'h1111, 16'h7777, 4'b1111}; // sub-wrap
    for (int i = 0; i < 5; i++) begin
      issue4(v[i].op, v[i].a, v[i].b);
      wait_done4(got, nb, ov);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL ovf_done[%0d]: got no done expected done", i); end
      checks++; if (bus4.res !== v[i].res) begin errors++; $display("FAIL ovf_res[%0d]: got %h expected %h", i, bus4.res, v[i].res); end
      checks++; if (bus4.ovf !== v[i].ovf) begin errors++; $display("FAIL ovf_flags[%0d]: got %b expected %b", i, bus4.ovf, v[i].ovf); end
      $display("overflow[%0d]: op=%b a=%h b=%h -> res=%h ovf=%b", i, v[i].op, v[i].a, v[i].b, bus4.res, bus4.ovf);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [4];
    int n = 0;
    int cyc = 0;
    int last = 0;
    v[0] = '{2'b00, 16'h1111, 16'h1111, 16'h2222, 4'b0000};
    v[1] = '{2'b00, 16'h1234, 16'h4321, 16'h5555, 4'b0000};
    v[2] = '{2'b00, 16'h7777, 16'h1111, 16'h7777, 4'b1111};
    v[3] = '{2'b00, 16'h0123, 16'h0111, 16'h0234, 4'b0000};
    bus4.start = 1'b1; bus4.op = v[0].op; bus4.a = v[0].a; bus4.b = v[0].b;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus4.busy === 1'b1 && bus4.done === 1'b1) begin
        checks++; errors++; $display("FAIL b2b_overlap: got busy&done at cycle %0d expected never", cyc);
      end
      if (bus4.done === 1'b1) begin
        checks++; if (cyc - last !== 5) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 5", n, cyc - last); end
        checks++; if (bus4.res !== v[n].res || bus4.ovf !== v[n].ovf) begin
          errors++; $display("FAIL b2b_res[%0d]: got %h/%b expected %h/%b", n, bus4.res, bus4.ovf, v[n].res, v[n].ovf);
        end
        $display("back_to_back[%0d]: done at cycle %0d res=%h ovf=%b", n, cyc, bus4.res, bus4.ovf);
        last = cyc;
        n++;
        if (n < 4) begin
          bus4.op = v[n].op; bus4.a = v[n].a; bus4.b = v[n].b;
        end else begin
          bus4.start = 1'b0;
        end
      end
    end
    bus4.start = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", n); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_midbusy();
    bit got, ov; int nb;
    issue4(2'b00, 16'h1234, 16'h4321);
    @(posedge clk); #1;
    bus4.start = 1'b1; bus4.op = 2'b10; bus4.a = 16'h7777; bus4.b = 16'h1111;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    wait_done4(got, nb, ov);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL mid_done: got no done expected done"); end
    checks++; if (nb !== 2) begin errors++; $display("FAIL mid_busy_left: got %0d expected 2", nb); end
    checks++; if (bus4.res !== 16'h5555 || bus4.ovf !== 4'b0000) begin
      errors++; $display("FAIL mid_res: got %h/%b expected 5555/0000", bus4.res, bus4.ovf);
    end
    $display("ignore_midbusy: res=%h ovf=%b", bus4.res, bus4.ovf);
    @(posedge clk); #1;
    checks++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
      errors++; $display("FAIL mid_no_restart: got busy=%b done=%b expected 0/0", bus4.busy, bus4.done);
    end
  endtask

  task automatic test_reset_midbusy();
    bit got, ov; int nb;
    bit saw_done = 0;
    issue4(2'b00, 16'h7777, 16'h1111);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_hs: got busy=%b done=%b expected 0/0", bus4.busy, bus4.done);
    end
    checks++; if (bus4.res !== 16'h0000 || bus4.ovf !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_res: got %h/%b expected 0000/0000", bus4.res, bus4.ovf);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (bus4.done === 1'b1) saw_done = 1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus4.done === 1'b1) saw_done = 1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got done pulse expected none"); end
    issue4(2'b00, 16'h0123, 16'h0111);
    wait_done4(got, nb, ov);
    checks++; if (got !== 1'b1 || nb !== 4) begin errors++; $display("FAIL rst_mid_restart: got done=%b busy=%0d expected 1/4", got, nb); end
    checks++; if (bus4.res !== 16'h0234 || bus4.ovf !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_restart_res: got %h/%b expected 0234/0000", bus4.res, bus4.ovf);
    end
    $display("reset_midbusy: restart res=%h ovf=%b", bus4.res, bus4.ovf);
    @(posedge clk); #1;
  endtask

  task automatic test_lane8();
    bit got, ov; int nb;
    issue8(2'b00, 16'h7F80, 16'h0180);
    wait_done8(got, nb, ov);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL l8_done: got no done expected done"); end
    checks++; if (nb !== 2) begin errors++; $display("FAIL l8_busy_len: got %0d expected 2", nb); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL l8_overlap: got busy&done expected never"); end
    checks++; if (bus8.res !== 16'h7F80) begin errors++; $display("FAIL l8_res: got %h expected 7F80", bus8.res); end
    checks++; if (bus8.ovf !== 2'b11) begin errors++; $display("FAIL l8_ovf: got %b expected 11", bus8.ovf); end
    $display("lane8: 7F80+0180 -> res=%h ovf=%b busy=%0d", bus8.res, bus8.ovf, nb);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add_sat();
    test_overflow();
    test_back_to_back();
    test_ignore_midbusy();
    test_reset_midbusy();
    test_lane8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
